keypad_scanner: RTL

Scans the 4x3 matrix keypad on the board, synchronizes and debounces the row returns, and produces the one-hot `keypad[9:0]` digit bus consumed by the clock/stopwatch/alarm top level. It also produces a one-cycle key strobe and a 4-bit key code. The block runs on the 1 kHz system clock and sits between the keypad pins and the mode-select top level.

---
 rtl/keypad_pkg.sv | 52 +++++
 rtl/keypad_scanner_sync.sv | 26 ++
 rtl/keypad_scanner.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the 4x3 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } kp_state_e;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 3;

  // Index of the set bit in a one-hot vector (0 if none set).
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Row/column position to key code: rows 0..2 hold digits 1..9, row 3 is * 0 #.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  // Digit code to the one-hot keypad level; * and # map to zero.
  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    logic [9:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) begin
      v[i] = (code == 4'(i));
    end
    return v;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// key_row_sync: parameterized-width 2-FF synchronizer, asynchronous reset to 0.
module key_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column scan, row debounce, one-hot digit level, strobe and code.
// Optional auto-repeat is compiled in with the KEYPAD_REPEAT_EN macro.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 5,
  parameter int DEBOUNCE_CNT  = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] key_row,
  output logic [N_COLS-1:0] key_col,
  output logic [9:0]        keypad,
  output logic [3:0]        key_code,
  output logic              key_valid
);

  localparam int DWELL_W = $clog2(SCAN_DIV + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 3 || DEBOUNCE_CNT < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("keypad_scanner: illegal parameter set");
  end

  logic [N_ROWS-1:0]  rs;
  kp_state_e          state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [N_COLS-1:0]  col_q, col_d;
  logic [N_ROWS-1:0]  row_q, row_d;
  logic [DB_W-1:0]    cnt_q, cnt_d;
  logic [9:0]         keypad_q, keypad_d;
  logic [3:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               rs_single;
  logic [3:0]         press_code;

  key_row_sync #(.WIDTH(N_ROWS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_row),
    .q   (rs)
  );

  // Exactly one row asserted; two or more rows means ghosting and is rejected.
  assign rs_single  = (rs != '0) && ((rs & (rs - 4'd1)) == '0);
  assign press_code = key_lookup(onehot_idx(row_q), onehot_idx({1'b0, col_q}));

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    keypad_d = keypad_q;
    code_d   = code_q;
    valid_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_W'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          col_d   = {col_q[N_COLS-2:0], col_q[N_COLS-1]};
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
        // First two dwell cycles still show the previous column through the synchronizer.
        if (dwell_q >= DWELL_W'(2) && rs_single) begin
          state_d = DEBOUNCE;
          row_d   = rs;
          cnt_d   = '0;
          dwell_d = '0;
          col_d   = col_q;
        end
      end
      DEBOUNCE: begin
        if (rs == row_q) begin
          if (cnt_q >= DB_W'(DEBOUNCE_CNT - 2)) begin
            state_d  = PRESSED;
            cnt_d    = '0;
            valid_d  = 1'b1;
            code_d   = press_code;
            keypad_d = digit_onehot(press_code);
`ifdef KEYPAD_REPEAT_EN
            hold_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
`ifdef KEYPAD_REPEAT_EN
        // Hold counter saturates one short of the delay and fires only while the key is still down.
        if (hold_q < HOLD_W'(REPEAT_DELAY - 1)) begin
          hold_d = hold_q + 1'b1;
        end else if (rs == row_q) begin
          valid_d = 1'b1;
          hold_d  = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
        end
`endif
        if (rs == '0) begin
          if (cnt_q >= DB_W'(DEBOUNCE_CNT - 1)) begin
            state_d  = SCAN;
            cnt_d    = '0;
            keypad_d = '0;
            code_d   = KEY_NONE;
`ifdef KEYPAD_REPEAT_EN
            hold_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SCAN;
      dwell_q  <= '0;
      col_q    <= 3'b001;
      row_q    <= '0;
      cnt_q    <= '0;
      keypad_q <= '0;
      code_q   <= KEY_NONE;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      keypad_q <= keypad_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign key_col   = col_q;
  assign keypad    = keypad_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule
